atm_session_ctrl: RTL and testbench

- Session sequencer for one ATM transaction.
- Takes the per-card password, the balance and `pass_en` from the card store.
- Verifies the user PIN with an attempt limit, then runs balance, withdraw and deposit operations on a working balance.
- Drives `updated_balance` / `operation_done` / `card_out` back to the card store so it commits the new balance, and ejects or retains the card.

---
 rtl/atm_session_ctrl_if.sv | 35 +++
 rtl/atm_session_ctrl.sv | 164 ++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_session_ctrl_if.sv
// Card-store / keypad bundle for the ATM session sequencer.
// master = card store + user side, slave = session controller.
interface atm_session_ctrl_if #(
  parameter int P_WIDTH = 16,
  parameter int B_WIDTH = 20
);
  logic               pass_en;
  logic [P_WIDTH-1:0] password;
  logic [B_WIDTH-1:0] balance;
  logic               pin_valid;
  logic [P_WIDTH-1:0] entered_pin;
  logic               op_valid;
  logic [1:0]         op_sel;
  logic [B_WIDTH-1:0] amount;
  logic [B_WIDTH-1:0] updated_balance;
  logic               operation_done;
  logic               card_out;
  logic               card_retained;
  logic               pin_error;
  logic               timeout;
  logic [1:0]         op_status;
  logic [2:0]         state;

  modport master (
    output pass_en, password, balance, pin_valid, entered_pin, op_valid, op_sel, amount,
    input  updated_balance, operation_done, card_out, card_retained, pin_error, timeout,
           op_status, state
  );

  modport slave (
    input  pass_en, password, balance, pin_valid, entered_pin, op_valid, op_sel, amount,
    output updated_balance, operation_done, card_out, card_retained, pin_error, timeout,
           op_status, state
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: PIN check with lockout, then inquiry/withdraw/deposit on a working balance.
// pin_valid->MENU 2 cycles, op_valid->operation_done 2 edges; no backpressure, strobes outside PIN_WAIT/MENU are dropped.
module atm_session_ctrl #(
  parameter int P_WIDTH        = 16,
  parameter int B_WIDTH        = 20,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int MAX_WITHDRAW   = 20000,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic             clk,
  input logic             rst,
  atm_session_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PIN_WAIT  = 3'd1;
  localparam logic [2:0] PIN_CHECK = 3'd2;
  localparam logic [2:0] MENU      = 3'd3;
  localparam logic [2:0] EXEC      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [2:0] EJECT     = 3'd6;

  localparam logic [1:0] OP_INQ  = 2'b00;
  localparam logic [1:0] OP_WD   = 2'b01;
  localparam logic [1:0] OP_DEP  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_FUNDS  = 2'b01;
  localparam logic [1:0] ST_LIMIT  = 2'b10;
  localparam logic [1:0] ST_OVFL   = 2'b11;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0]      ATT_LIMIT  = AW'(MAX_ATTEMPTS);
  localparam logic [B_WIDTH-1:0] WD_LIMIT   = B_WIDTH'(MAX_WITHDRAW);

  logic [2:0]         state_q, state_d;
  logic [P_WIDTH-1:0] pw_reg, pin_reg;
  logic [B_WIDTH-1:0] bal_q, amt_reg;
  logic [1:0]         op_reg, status_q;
  logic [TW-1:0]      timer_q;
  logic [AW-1:0]      attempts_q;
  logic               retained_q, timeout_q;

  logic               pin_match;
  logic               timer_hit;
  logic [AW-1:0]      attempts_inc;
  logic [B_WIDTH:0]   dep_sum;

  assign pin_match    = (pin_reg == pw_reg);
  assign timer_hit    = (timer_q == TIMER_LAST);
  assign attempts_inc = attempts_q + 1'b1;
  assign dep_sum      = {1'b0, bal_q} + {1'b0, amt_reg};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.pass_en) state_d = PIN_WAIT;
      // A strobe arriving in the last idle cycle beats the timeout.
      PIN_WAIT: begin
        if (bus.pin_valid)  state_d = PIN_CHECK;
        else if (timer_hit) state_d = EJECT;
      end
      PIN_CHECK: begin
        if (pin_match)                      state_d = MENU;
        else if (attempts_inc == ATT_LIMIT) state_d = EJECT;
        else                                state_d = PIN_WAIT;
      end
      MENU: begin
        if (bus.op_valid)   state_d = (bus.op_sel == OP_EXIT) ? EJECT : EXEC;
        else if (timer_hit) state_d = EJECT;
      end
      EXEC:    state_d = DONE;
      DONE:    state_d = MENU;
      EJECT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pw_reg     <= '0;
      pin_reg    <= '0;
      bal_q      <= '0;
      amt_reg    <= '0;
      op_reg     <= '0;
      status_q   <= '0;
      timer_q    <= '0;
      attempts_q <= '0;
      retained_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.pass_en) begin
            pw_reg     <= bus.password;
            bal_q      <= bus.balance;
            attempts_q <= '0;
            timer_q    <= '0;
            retained_q <= 1'b0;
            timeout_q  <= 1'b0;
            status_q   <= ST_OK;
          end
        end
        PIN_WAIT: begin
          if (bus.pin_valid)  pin_reg   <= bus.entered_pin;
          else if (timer_hit) timeout_q <= 1'b1;
          else                timer_q   <= timer_q + 1'b1;
        end
        PIN_CHECK: begin
          timer_q <= '0;
          if (pin_match) begin
            attempts_q <= '0;
          end else begin
            attempts_q <= attempts_inc;
            if (attempts_inc == ATT_LIMIT) retained_q <= 1'b1;
          end
        end
        MENU: begin
          if (bus.op_valid) begin
            op_reg  <= bus.op_sel;
            amt_reg <= bus.amount;
          end else if (timer_hit) begin
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        EXEC: begin
          status_q <= ST_OK;
          case (op_reg)
            // Per-operation limit is checked before available funds.
            OP_WD: begin
              if (amt_reg > WD_LIMIT)   status_q <= ST_LIMIT;
              else if (amt_reg > bal_q) status_q <= ST_FUNDS;
              else                      bal_q    <= bal_q - amt_reg;
            end
            OP_DEP: begin
              if (dep_sum[B_WIDTH]) status_q <= ST_OVFL;
              else                  bal_q    <= dep_sum[B_WIDTH-1:0];
            end
            default: ;
          endcase
        end
        DONE:    timer_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.updated_balance = bal_q;
  assign bus.operation_done  = (state_q == DONE);
  assign bus.card_out        = (state_q == EJECT);
  assign bus.card_retained   = retained_q;
  assign bus.pin_error       = (state_q == PIN_CHECK) && !pin_match;
  assign bus.timeout         = timeout_q;
  assign bus.op_status       = status_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: login, lockout, withdraw/deposit limits, timeouts, exit, mid-session reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_atm_session_ctrl;
  localparam int PW = 16;
  localparam int BW = 20;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  atm_session_ctrl_if #(.P_WIDTH(PW), .B_WIDTH(BW)) bus ();

  atm_session_ctrl #(
    .P_WIDTH(PW), .B_WIDTH(BW), .MAX_ATTEMPTS(3),
    .MAX_WITHDRAW(20000), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Inserts a card and enters the correct PIN; ends in MENU.
  task automatic login(input logic [15:0] pw, input logic [19:0] bal);
    bus.pass_en  = 1'b1;
    bus.password = pw;
    bus.balance  = bal;
    cycle();
    bus.pass_en = 1'b0;
    chk("login_pin_wait", bus.state, 1);
    chk("login_retained_clr", bus.card_retained, 0);
    chk("login_timeout_clr", bus.timeout, 0);
    chk("login_bal_latch", bus.updated_balance, bal);
    bus.pin_valid   = 1'b1;
    bus.entered_pin = pw;
    cycle();
    bus.pin_valid = 1'b0;
    cycle();
    chk("login_menu", bus.state, 3);
  endtask

  // Issues one operation from MENU; ends in DONE.
  task automatic do_op(input logic [1:0] sel, input logic [19:0] amt);
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.amount   = amt;
    cycle();
    bus.op_valid = 1'b0;
    cycle();
    chk("op_done_pulse", bus.operation_done, 1);
  endtask

  task automatic exit_session();
    bus.op_valid = 1'b1;
    bus.op_sel   = 2'b11;
    cycle();
    bus.op_valid = 1'b0;
    chk("exit_card_out", bus.card_out, 1);
    chk("exit_no_done", bus.operation_done, 0);
    cycle();
    chk("exit_idle", bus.state, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.pass_en = 1'b0; bus.password = '0; bus.balance = '0;
    bus.pin_valid = 1'b0; bus.entered_pin = '0;
    bus.op_valid = 1'b0; bus.op_sel = '0; bus.amount = '0;

    // Reset state
    cycle(); cycle();
    chk("rst_state", bus.state, 0);
    chk("rst_balance", bus.updated_balance, 0);
    chk("rst_outputs", {bus.operation_done, bus.card_out, bus.card_retained,
                        bus.pin_error, bus.timeout, bus.op_status}, 0);
    rst = 1'b1;
    cycle();

    // 1. Login with latency checks, withdraw 15000 from 50000
    bus.pass_en = 1'b1; bus.password = 16'h3506; bus.balance = 20'd50000;
    cycle();
    bus.pass_en = 1'b0;
    chk("t1_pin_wait", bus.state, 1);
    chk("t1_bal", bus.updated_balance, 50000);
    bus.pin_valid = 1'b1; bus.entered_pin = 16'h3506;
    cycle();
    bus.pin_valid = 1'b0;
    chk("t1_pin_check", bus.state, 2);
    chk("t1_no_pin_err", bus.pin_error, 0);
    cycle();
    chk("t1_menu_after_2", bus.state, 3);
    bus.op_valid = 1'b1; bus.op_sel = 2'b01; bus.amount = 20'd15000;
    cycle();
    bus.op_valid = 1'b0;
    chk("t1_exec", bus.state, 4);
    chk("t1_exec_no_done", bus.operation_done, 0);
    cycle();
    chk("t1_done", bus.operation_done, 1);
    chk("t1_bal_35000", bus.updated_balance, 35000);
    chk("t1_status_ok", bus.op_status, 0);
    cycle();
    chk("t1_back_menu", bus.state, 3);
    chk("t1_done_one_cycle", bus.operation_done, 0);

    // 6a. Exit: card_out without operation_done, balance held into IDLE
    exit_session();
    chk("t6_bal_held", bus.updated_balance, 35000);
    chk("t6_card_out_one_cycle", bus.card_out, 0);

    // 2. Three wrong PINs -> retention, 4th pin ignored
    bus.pass_en = 1'b1; bus.password = 16'h3506; bus.balance = 20'd1234;
    cycle();
    bus.pass_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pin_valid = 1'b1; bus.entered_pin = 16'h1111;
      cycle();
      bus.pin_valid = 1'b0;
      chk("t2_pin_err", bus.pin_error, 1);
      cycle();
      chk("t2_pin_err_pulse", bus.pin_error, 0);
      chk("t2_next_state", bus.state, (i < 2) ? 1 : 6);
      chk("t2_retained", bus.card_retained, (i < 2) ? 0 : 1);
      chk("t2_card_out", bus.card_out, (i < 2) ? 0 : 1);
    end
    cycle();
    chk("t2_idle", bus.state, 0);
    chk("t2_retained_held", bus.card_retained, 1);
    chk("t2_card_out_once", bus.card_out, 0);
    bus.pin_valid = 1'b1; bus.entered_pin = 16'h1111;
    cycle();
    bus.pin_valid = 1'b0;
    chk("t2_4th_ignored", bus.state, 0);
    chk("t2_4th_no_err", bus.pin_error, 0);

    // 3. Withdraw rejections and edge amounts, balance 2200
    login(16'h3506, 20'd2200);
    do_op(2'b01, 20'd5000);
    chk("t3_funds_status", bus.op_status, 1);
    chk("t3_funds_bal", bus.updated_balance, 2200);
    cycle();
    chk("t3_status_held", bus.op_status, 1);
    do_op(2'b01, 20'd25000);
    chk("t3_limit_status", bus.op_status, 2);
    chk("t3_limit_bal", bus.updated_balance, 2200);
    cycle();
    do_op(2'b01, 20'd2200);
    chk("t3_exact_status", bus.op_status, 0);
    chk("t3_exact_bal", bus.updated_balance, 0);
    cycle();
    do_op(2'b10, 20'd0);
    chk("t3_zero_status", bus.op_status, 0);
    chk("t3_zero_bal", bus.updated_balance, 0);
    cycle();
    exit_session();

    // 4. Deposit overflow boundary and withdraw limit boundary
    login(16'h3506, 20'd1000000);
    do_op(2'b10, 20'd48576);
    chk("t4_ovfl_status", bus.op_status, 3);
    chk("t4_ovfl_bal", bus.updated_balance, 1000000);
    cycle();
    do_op(2'b10, 20'd48575);
    chk("t4_max_status", bus.op_status, 0);
    chk("t4_max_bal", bus.updated_balance, 1048575);
    cycle();
    do_op(2'b01, 20'd20001);
    chk("t4_over_limit", bus.op_status, 2);
    chk("t4_over_limit_bal", bus.updated_balance, 1048575);
    cycle();
    do_op(2'b01, 20'd20000);
    chk("t4_at_limit", bus.op_status, 0);
    chk("t4_at_limit_bal", bus.updated_balance, 1028575);
    cycle();
    exit_session();

    // 5a. PIN_WAIT timeout after 1000 idle cycles
    bus.pass_en = 1'b1; bus.password = 16'h3506; bus.balance = 20'd500;
    cycle();
    bus.pass_en = 1'b0;
    repeat (999) cycle();
    chk("t5_still_wait", bus.state, 1);
    chk("t5_no_timeout_yet", bus.timeout, 0);
    cycle();
    chk("t5_eject", bus.state, 6);
    chk("t5_timeout", bus.timeout, 1);
    chk("t5_card_out", bus.card_out, 1);
    cycle();
    chk("t5_idle", bus.state, 0);
    chk("t5_timeout_held", bus.timeout, 1);

    // 5b. pin_valid at timer==999 wins
    bus.pass_en = 1'b1;
    cycle();
    bus.pass_en = 1'b0;
    chk("t5b_timeout_clr", bus.timeout, 0);
    repeat (999) cycle();
    bus.pin_valid = 1'b1; bus.entered_pin = 16'h3506;
    cycle();
    bus.pin_valid = 1'b0;
    chk("t5b_pin_check", bus.state, 2);
    chk("t5b_no_timeout", bus.timeout, 0);
    cycle();
    chk("t5b_menu", bus.state, 3);

    // 5c. op_valid at MENU timer==999 wins, then MENU timeout
    repeat (999) cycle();
    bus.op_valid = 1'b1; bus.op_sel = 2'b00; bus.amount = 20'd0;
    cycle();
    bus.op_valid = 1'b0;
    chk("t5c_exec", bus.state, 4);
    chk("t5c_no_timeout", bus.timeout, 0);
    cycle();
    chk("t5c_done", bus.operation_done, 1);
    chk("t5c_bal", bus.updated_balance, 500);
    cycle();
    repeat (999) cycle();
    chk("t5c_still_menu", bus.state, 3);
    cycle();
    chk("t5c_eject", bus.state, 6);
    chk("t5c_timeout", bus.timeout, 1);
    cycle();

    // 6b. Reset asserted during EXEC
    login(16'h3506, 20'd777);
    bus.op_valid = 1'b1; bus.op_sel = 2'b01; bus.amount = 20'd100;
    cycle();
    bus.op_valid = 1'b0;
    chk("t6b_in_exec", bus.state, 4);
    rst = 1'b0;
    #1;
    chk("t6b_rst_state", bus.state, 0);
    chk("t6b_rst_bal", bus.updated_balance, 0);
    chk("t6b_rst_outputs", {bus.operation_done, bus.card_out, bus.card_retained,
                            bus.pin_error, bus.timeout, bus.op_status}, 0);
    cycle(); cycle();
    chk("t6b_no_pulses", {bus.operation_done, bus.card_out}, 0);
    rst = 1'b1;
    cycle();
    chk("t6b_idle_after", bus.state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
